uart_tx_fsm: RTL and testbench

UART transmit engine, the TX-side counterpart of the RX frame sequencer in the apb-uart core. It accepts one byte per valid/ready handshake and serialises it on tx_o as a frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. Bit timing comes from an internal per-bit cycle counter loaded from clk_div_i. It sits between the TX FIFO read port and the UART TX pin.

---
 rtl/uart_tx_fsm.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmit engine: accepts one byte per valid/ready handshake and shifts out
// start, 8 data bits LSB-first, optional parity and 1-2 stop bits on a registered line.
module uart_tx_fsm #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CLK_DIV_W-1:0] clk_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop_bits_i,
  input  logic [7:0]           data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_BIT  = 4'd1,
    DATA_0     = 4'd2,
    DATA_1     = 4'd3,
    DATA_2     = 4'd4,
    DATA_3     = 4'd5,
    DATA_4     = 4'd6,
    DATA_5     = 4'd7,
    DATA_6     = 4'd8,
    DATA_7     = 4'd9,
    PARITY_BIT = 4'd10,
    STOP_1     = 4'd11,
    STOP_2     = 4'd12
  } state_e;

  localparam logic [CLK_DIV_W-1:0] DIV_ONE = CLK_DIV_W'(1);

  state_e               state_q, state_d;
  logic [CLK_DIV_W-1:0] cnt_q, cnt_d;
  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // The current bit period ends on the last of its N cycles.
  assign bit_end = (cnt_q == (div_q - DIV_ONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          state_d   = START_BIT;
          shift_d   = data_i;
          div_d     = (clk_div_i == '0) ? DIV_ONE : clk_div_i;
          par_en_d  = parity_en_i;
          par_bit_d = (^data_i) ^ parity_odd_i;
          stop2_d   = stop_bits_i;
        end
      end
      START_BIT: begin
        if (bit_end) state_d = DATA_0;
      end
      DATA_0, DATA_1, DATA_2, DATA_3, DATA_4, DATA_5, DATA_6: begin
        if (bit_end) begin
          state_d = state_e'(state_q + 4'd1);
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA_7: begin
        if (bit_end) state_d = par_en_q ? PARITY_BIT : STOP_1;
      end
      PARITY_BIT: begin
        if (bit_end) state_d = STOP_1;
      end
      STOP_1: begin
        if (bit_end) begin
          state_d = stop2_q ? STOP_2 : IDLE;
          done_d  = ~stop2_q;
        end
      end
      STOP_2: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter restarts on every state change and only runs inside a frame.
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_ONE;
    end

    // tx is registered from the state being entered so the line matches the current state.
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA_0, DATA_1, DATA_2, DATA_3,
      DATA_4, DATA_5, DATA_6, DATA_7: tx_d = shift_d[0];
      PARITY_BIT: tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_ONE;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign data_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign tx_o         = tx_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a frame-level waveform model checked every cycle, plus
// directed literal checks on frame length, parity, stop bits, back-to-back and reset.
module tb_uart_tx_fsm;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] clk_div = '0;
  logic         par_en = 1'b0;
  logic         par_odd = 1'b0;
  logic         stop2 = 1'b0;
  logic [7:0]   data = '0;
  logic         valid = 1'b0;
  logic         data_ready_o, tx_o, busy_o, done_o;

  always #5 clk = ~clk;

  uart_tx_fsm #(.CLK_DIV_W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clk_div_i   (clk_div),
    .parity_en_i (par_en),
    .parity_odd_i(par_odd),
    .stop_bits_i (stop2),
    .data_i      (data),
    .data_valid_i(valid),
    .data_ready_o(data_ready_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Model: expected {ready, done, busy, tx} for every cycle, queued per frame.
  localparam logic [3:0] IDLE_V = 4'b1001;
  logic [3:0] cur = IDLE_V;
  logic       chk_en = 1'b0;
  logic [3:0] exp_q[$];

  function automatic void push_frame(input logic [7:0] d, input logic [W-1:0] div,
                                     input logic pe, input logic po, input logic sb);
    int   n;
    logic b[$];
    n = (div == 0) ? 1 : int'(div);
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back((^d) ^ po);
    b.push_back(1'b1);
    if (sb) b.push_back(1'b1);
    foreach (b[k]) begin
      for (int r = 0; r < n; r++) exp_q.push_back({1'b0, 1'b0, 1'b1, b[k]});
    end
    exp_q.push_back(4'b1101);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        cur = IDLE_V;
        chk_en = 1'b1;
      end else begin
        if (chk_en && cur[3] && valid) push_frame(data, clk_div, par_en, par_odd, stop2);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = IDLE_V;
      end
    end
  end

  // Per-cycle compare and frame monitor.
  int   cyc = 0, start_cyc = 0, busy_cnt = 0, last_len = 0, last_busy = 0;
  int   done_cnt = 0, last_done = 0, prev_done = 0;
  logic prev_busy = 1'b0;
  logic frame_tx[64];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_assert++;
        if ({data_ready_o, done_o, busy_o, tx_o} !== cur) begin
          n_fail++;
          $display("FAIL cycle_model @%0d: got rdy/done/busy/tx=%b required %b",
                   cyc, {data_ready_o, done_o, busy_o, tx_o}, cur);
        end
      end
      cyc++;
      if (busy_o && !prev_busy) begin
        start_cyc = cyc;
        busy_cnt = 0;
      end
      if (busy_o) begin
        busy_cnt++;
        if (cyc - start_cyc < 64) frame_tx[cyc - start_cyc] = tx_o;
      end
      if (done_o) begin
        last_len = cyc - start_cyc;
        last_busy = busy_cnt;
        prev_done = last_done;
        last_done = cyc;
        done_cnt++;
      end
      prev_busy = busy_o;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [W-1:0] div,
                       input logic pe, input logic po, input logic sb);
    data = d; clk_div = div; par_en = pe; par_odd = po; stop2 = sb; valid = 1'b1;
  endtask

  // Returns positioned in the first start-bit cycle after the handshake edge.
  task automatic wait_accept(input string name);
    int k = 0;
    while (!data_ready_o && k < 300) begin
      step();
      k++;
    end
    if (!data_ready_o) check({name, "_accept_timeout"}, 0, 1);
    step();
  endtask

  task automatic wait_done(input string name, input int target);
    int k = 0;
    while (done_cnt < target && k < 300) begin
      step();
      k++;
    end
    if (done_cnt < target) check({name, "_done_timeout"}, done_cnt, target);
  endtask

  initial begin
    int d0;
    int zeros;
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int zeros;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_tx", tx_o, 1);
    check("rst_ready", data_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);

    // 0x55, N=4, no parity, one stop
    d0 = done_cnt;
    drive(8'h55, 16'd4, 1'b0, 1'b0, 1'b0);
    wait_accept("t1");
    valid = 1'b0;
    wait_done("t1", d0 + 1);
    check("t1_len", last_len, 40);
    check("t1_busy_cycles", last_busy, 40);
    check("t1_start", frame_tx[0], 0);
    check("t1_start_end", frame_tx[3], 0);
    check("t1_bit0", frame_tx[4], 1);
    check("t1_bit1", frame_tx[8], 0);
    check("t1_stop", frame_tx[36], 1);

    // 0x07, N=2, even then odd parity
    d0 = done_cnt;
    drive(8'h07, 16'd2, 1'b1, 1'b0, 1'b0);
    wait_accept("t2e");
    valid = 1'b0;
    wait_done("t2e", d0 + 1);
    check("t2_even_len", last_len, 22);
    check("t2_even_parity", frame_tx[18], 1);
    d0 = done_cnt;
    drive(8'h07, 16'd2, 1'b1, 1'b1, 1'b0);
    wait_accept("t2o");
    valid = 1'b0;
    wait_done("t2o", d0 + 1);
    check("t2_odd_len", last_len, 22);
    check("t2_odd_parity", frame_tx[18], 0);

    // 0xA0, N=3, two stops, mid-frame valid and input changes ignored
    d0 = done_cnt;
    drive(8'hA0, 16'd3, 1'b0, 1'b0, 1'b1);
    wait_accept("t3");
    valid = 1'b0;
    repeat (5) step();
    drive(8'h3C, 16'd1, 1'b1, 1'b1, 1'b0);
    check("t3_ready_midframe", data_ready_o, 0);
    repeat (3) step();
    valid = 1'b0;
    wait_done("t3", d0 + 1);
    check("t3_len", last_len, 33);
    check("t3_bit5", frame_tx[18], 1);
    check("t3_bit7", frame_tx[24], 1);
    check("t3_stop1", frame_tx[27], 1);
    check("t3_stop2_end", frame_tx[32], 1);
    repeat (3) step();
    check("t3_no_extra_frame", busy_o, 0);

    // back-to-back 0x01 then 0x80 at N=1
    d0 = done_cnt;
    drive(8'h01, 16'd1, 1'b0, 1'b0, 1'b0);
    wait_accept("t4a");
    data = 8'h80;
    wait_accept("t4b");
    valid = 1'b0;
    wait_done("t4", d0 + 2);
    check("t4_done_spacing", last_done - prev_done, 11);
    check("t4_gap", start_cyc - prev_done, 1);
    check("t4_second_bit0", frame_tx[1], 0);
    check("t4_second_bit7", frame_tx[8], 1);

    // reset during DATA_3, then a clean frame
    d0 = done_cnt;
    drive(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0);
    wait_accept("t5");
    valid = 1'b0;
    repeat (17) step();
    check("t5_data3_bit", tx_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_tx", tx_o, 1);
    check("t5_rst_ready", data_ready_o, 1);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_done", done_o, 0);
    repeat (5) step();
    check("t5_no_done", done_cnt, d0);
    drive(8'hC3, 16'd2, 1'b1, 1'b1, 1'b1);
    wait_accept("t5b");
    valid = 1'b0;
    wait_done("t5b", d0 + 1);
    check("t5_after_len", last_len, 24);

    // clk_div=0 behaves as N=1
    d0 = done_cnt;
    drive(8'hFF, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_accept("t6");
    valid = 1'b0;
    wait_done("t6", d0 + 1);
    check("t6_len", last_len, 10);
    zeros = 0;
    for (int i = 0; i < 10; i++) if (frame_tx[i] == 1'b0) zeros++;
    check("t6_low_cycles", zeros, 1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
